// File: rtl/sync_ram.sv
// Single-port synchronous scratch RAM with a registered, write-through read port.
// An asynchronous active-low reset clears both the storage array and the output register.
module sync_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int DEPTH = 32'd1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] dout_r;

    // Storage array: the whole array is cleared on reset so contents are deterministic afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (we) begin
            mem_r[addr] <= din;
        end else begin
            mem_r[addr] <= mem_r[addr];
        end
    end

    // Output register: on a write the new data is forwarded, so dout never shows the stale word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_r <= '0;
        end else if (we) begin
            dout_r <= din;
        end else begin
            dout_r <= mem_r[addr];
        end
    end

    assign dout = dout_r;

endmodule

// File: tb/tb_sync_ram.sv
// Self-checking bench for sync_ram: directed steps from the test plan followed by
// random accesses, all checked against a simple array model of the memory.
module tb_sync_ram;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst_n;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] ref_dout;

    sync_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (we),
        .addr (addr),
        .din  (din),
        .dout (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        ref_dout = '0;
    endtask

    // One access: drive on the falling edge, let the rising edge act, then compare.
    task automatic access(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input string tag);
        @(negedge clk);
        we = w; addr = a; din = d;
        @(posedge clk);
        #1;
        if (w) begin
            ref_mem[a] = d;
            ref_dout   = d;
        end else begin
            ref_dout = ref_mem[a];
        end
        check(tag, dout, ref_dout);
    endtask

    initial begin
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;
        logic          rw;
        logic [AW-1:0] rst_addrs [4];
        rst_addrs[0] = 4'd0; rst_addrs[1] = 4'd1; rst_addrs[2] = 4'd2; rst_addrs[3] = 4'd15;

        // Reset held across clock edges with a write pending; it must be ignored.
        rst_n = 1'b0; we = 1'b1; addr = 4'd1; din = 8'h99;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_dout", dout, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        we = 1'b0;
        foreach (rst_addrs[i]) access(1'b0, rst_addrs[i], 8'h00, "reset_read");

        // Write then read back.
        access(1'b1, 4'd0, 8'hA5, "wr0");
        access(1'b1, 4'd1, 8'h3C, "wr1");
        access(1'b1, 4'd2, 8'h7E, "wr2");
        access(1'b0, 4'd0, 8'h00, "rd0");
        check("rd0_const", dout, 8'hA5);
        access(1'b0, 4'd1, 8'h00, "rd1");
        check("rd1_const", dout, 8'h3C);
        access(1'b0, 4'd2, 8'h00, "rd2");
        check("rd2_const", dout, 8'h7E);

        // Write-first.
        access(1'b1, 4'd3, 8'h5A, "wfirst");
        check("wfirst_const", dout, 8'h5A);
        access(1'b0, 4'd3, 8'h00, "wfirst_rd");

        // Overwrite at top address and neighbour unaffected.
        access(1'b1, 4'd15, 8'hFF, "wr15a");
        access(1'b1, 4'd15, 8'h01, "wr15b");
        access(1'b0, 4'd15, 8'h00, "rd15");
        check("rd15_const", dout, 8'h01);
        access(1'b0, 4'd0, 8'h00, "rd0_after");
        check("rd0_after_const", dout, 8'hA5);

        // Hold: wiggle inputs between edges, dout must not move.
        for (int k = 0; k < 4; k++) begin
            #1;
            addr = AW'($urandom);
            din  = DW'($urandom);
            we   = (k == 2) ? 1'b1 : 1'b0;
            #1;
            check("hold", dout, ref_dout);
        end
        access(1'b0, 4'd2, 8'h00, "hold_next_edge");

        // Async reset pulse between edges with a write set up but not clocked.
        @(negedge clk);
        we = 1'b1; addr = 4'd5; din = 8'hC3;
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_reset_dout", dout, 8'h00);
        #1;
        rst_n = 1'b1;
        we = 1'b0;
        foreach (rst_addrs[i]) access(1'b0, rst_addrs[i], 8'h00, "post_reset_read");
        access(1'b0, 4'd5, 8'h00, "lost_write");

        // Random traffic against the model.
        for (int n = 0; n < 300; n++) begin
            rw = ($urandom_range(0, 1) == 1);
            ra = AW'($urandom);
            rd = DW'($urandom);
            access(rw, ra, rd, "random");
        end

        // Full readback sweep.
        for (int a = 0; a < DEPTH; a++) access(1'b0, AW'(a), 8'h00, "sweep");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
